// File: rtl/rf_echo_sequencer.sv
// Purpose : triggered spin-echo scheduler driving the RF switch gate and the acquisition gate.
// Latency : rf rises on the 3rd clk edge after trig is first sampled high (2 sync FFs + edge reg).
// Backpressure: none; trig edges while a sequence runs (or in the DONE cycle) are dropped, not queued.
//
// Ports:
//   clk, rst      single clock, synchronous active-high reset (overrides everything)
//   trig          asynchronous trigger; synchronised here, rising edge starts a sequence
//   abort         synchronous level abort; returns to IDLE next cycle with all outputs low
//   cfg_pi2/tau/acq/gap/reps   configuration, latched into shadow registers at start
//   cfg_npi       pi pulses per repetition (only with SEQ_CPMG_EN defined)
//   rf, acq       registered RF gate and acquisition gate (never high together)
//   busy, done    busy from start until completion; done is a one-cycle completion pulse
//
// Build option: define SEQ_CPMG_EN for the multi-pi (CPMG) train with the T3 refocus delay.
module rf_echo_sequencer #(
    parameter int CNT_W = 24,
    parameter int REP_W = 16,
    parameter int NPI_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trig,
    input  logic             abort,
    input  logic [CNT_W-1:0] cfg_pi2,
    input  logic [CNT_W-1:0] cfg_tau,
    input  logic [CNT_W-1:0] cfg_acq,
    input  logic [CNT_W-1:0] cfg_gap,
    input  logic [REP_W-1:0] cfg_reps,
`ifdef SEQ_CPMG_EN
    input  logic [NPI_W-1:0] cfg_npi,
`endif
    output logic             rf,
    output logic             acq,
    output logic             busy,
    output logic             done
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_P90,
        S_T1,
        S_P180,
        S_T2,
        S_ACQ,
        S_GAP,
        S_DONE
`ifdef SEQ_CPMG_EN
        ,
        S_T3
`endif
    } state_t;

    state_t r_state;
    state_t w_nxt;

    // Trigger synchroniser and edge register
    logic r_trig_s1;
    logic r_trig_s2;
    logic r_trig_d;
    logic w_trig_rise;
    logic w_start;

    // Shadow configuration, zero-clamped at latch time
    logic [CNT_W-1:0] r_pi2;
    logic [CNT_W-1:0] r_tau;
    logic [CNT_W-1:0] r_acq;
    logic [CNT_W-1:0] r_gap;
    logic [REP_W-1:0] r_reps_left;
`ifdef SEQ_CPMG_EN
    logic [NPI_W-1:0] r_npi;
    logic [NPI_W-1:0] r_pi_left;
`endif

    // Shared phase counter; one bit wider so the doubled pi width fits
    logic [CNT_W:0] r_cnt;
    logic [CNT_W:0] w_dur;
    logic           w_phase_end;

    logic r_rf;
    logic r_acq_o;
    logic r_busy;
    logic r_done;

    assign rf   = r_rf;
    assign acq  = r_acq_o;
    assign busy = r_busy;
    assign done = r_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_trig_s1 <= 1'b0;
            r_trig_s2 <= 1'b0;
            r_trig_d  <= 1'b0;
        end else begin
            r_trig_s1 <= trig;
            r_trig_s2 <= r_trig_s1;
            r_trig_d  <= r_trig_s2;
        end
    end

    assign w_trig_rise = r_trig_s2 & ~r_trig_d;
    // abort beats a coincident trigger edge
    assign w_start     = (r_state == S_IDLE) && w_trig_rise && !abort;

    // Duration of the phase currently running
    always_comb begin
        w_dur = (CNT_W+1)'(1);
        case (r_state)
            S_P90:  w_dur = {1'b0, r_pi2};
            S_P180: w_dur = {r_pi2, 1'b0};
            S_T1,
            S_T2:   w_dur = {1'b0, r_tau};
`ifdef SEQ_CPMG_EN
            S_T3:   w_dur = {1'b0, r_tau};
`endif
            S_ACQ:  w_dur = {1'b0, r_acq};
            S_GAP:  w_dur = {1'b0, r_gap};
            default: w_dur = (CNT_W+1)'(1);
        endcase
    end

    // Durations are clamped to >= 1, so dur-1 never wraps
    assign w_phase_end = (r_cnt == w_dur - 1'b1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nxt;
        end
    end

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_start)     w_nxt = S_P90;
            S_P90:  if (w_phase_end) w_nxt = S_T1;
            S_T1:   if (w_phase_end) w_nxt = S_P180;
            S_P180: if (w_phase_end) w_nxt = S_T2;
            S_T2:   if (w_phase_end) w_nxt = S_ACQ;
            S_ACQ: begin
                if (w_phase_end) begin
`ifdef SEQ_CPMG_EN
                    if (r_pi_left != NPI_W'(1))
                        w_nxt = S_T3;
                    else
`endif
                    if (r_reps_left == REP_W'(1))
                        w_nxt = S_DONE;
                    else
                        w_nxt = S_GAP;
                end
            end
`ifdef SEQ_CPMG_EN
            S_T3:   if (w_phase_end) w_nxt = S_P180;
`endif
            S_GAP:  if (w_phase_end) w_nxt = S_P90;
            S_DONE: w_nxt = S_IDLE;
            default: w_nxt = S_IDLE;
        endcase
        if (abort && (r_state != S_IDLE))
            w_nxt = S_IDLE;
    end

    // Outputs are registered from the next state so they line up with the state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_rf        <= 1'b0;
            r_acq_o     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pi2       <= '0;
            r_tau       <= '0;
            r_acq       <= '0;
            r_gap       <= '0;
            r_reps_left <= '0;
`ifdef SEQ_CPMG_EN
            r_npi       <= '0;
            r_pi_left   <= '0;
`endif
        end else begin
            // counter restarts on every phase entry
            if ((w_nxt != r_state) || (r_state == S_IDLE))
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 1'b1;

            r_rf    <= (w_nxt == S_P90) || (w_nxt == S_P180);
            r_acq_o <= (w_nxt == S_ACQ);
            r_busy  <= (w_nxt != S_IDLE) && (w_nxt != S_DONE);
            r_done  <= (w_nxt == S_DONE);

            if (w_start) begin
                r_pi2       <= (cfg_pi2  == '0) ? CNT_W'(1) : cfg_pi2;
                r_tau       <= (cfg_tau  == '0) ? CNT_W'(1) : cfg_tau;
                r_acq       <= (cfg_acq  == '0) ? CNT_W'(1) : cfg_acq;
                r_gap       <= (cfg_gap  == '0) ? CNT_W'(1) : cfg_gap;
                r_reps_left <= (cfg_reps == '0) ? REP_W'(1) : cfg_reps;
`ifdef SEQ_CPMG_EN
                r_npi       <= (cfg_npi  == '0) ? NPI_W'(1) : cfg_npi;
                r_pi_left   <= (cfg_npi  == '0) ? NPI_W'(1) : cfg_npi;
`endif
            end

            if ((r_state == S_ACQ) && (w_nxt == S_GAP)) begin
                r_reps_left <= r_reps_left - 1'b1;
`ifdef SEQ_CPMG_EN
                // every repetition gets the full pi train again
                r_pi_left   <= r_npi;
`endif
            end

`ifdef SEQ_CPMG_EN
            if ((r_state == S_ACQ) && (w_nxt == S_T3))
                r_pi_left <= r_pi_left - 1'b1;
`endif
        end
    end

endmodule
